// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, one in-flight imem read, 2-entry output buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_trap
);

    logic [31:0] pc_q;
    logic        inflight_v;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic [31:0] head_instr, head_pc;
    logic [31:0] tail_instr, tail_pc;
    logic        trap_q;

    logic [31:0] target;
    logic        bad_target;
    logic        pop, push, issue;
    logic [1:0]  left;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign bad_target = redirect_pc[1:0] != 2'b00;
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign target     = {redirect_pc[31:2], 2'b00};
    assign bad_target = 1'b0;
`endif

    assign imem_addr     = pc_q;
    assign out_valid     = count != 2'd0;
    assign out_instr     = head_instr;
    assign out_pc        = head_pc;
    assign out_pc_plus4  = head_pc + 32'd4;
    assign misalign_trap = trap_q;

    assign pop   = out_valid & out_ready;
    assign push  = inflight_v & ~redirect_valid;
    // Reserve a buffer slot for every outstanding read before issuing
    assign issue = ~redirect_valid & ~trap_q &
                   (((count + {1'b0, inflight_v}) < 2'd2) | pop);
    assign left  = count - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= 32'd0;
            count       <= 2'd0;
            head_instr  <= 32'd0;
            head_pc     <= 32'd0;
            tail_instr  <= 32'd0;
            tail_pc     <= 32'd0;
            trap_q      <= 1'b0;
        end else begin
            if (redirect_valid)
                pc_q <= target;
            else if (issue)
                pc_q <= pc_q + 32'd4;

            inflight_v <= issue;
            if (issue)
                inflight_pc <= pc_q;

            if (pop) begin
                head_instr <= tail_instr;
                head_pc    <= tail_pc;
            end
            if (push) begin
                if (left == 2'd0) begin
                    head_instr <= instr_in;
                    head_pc    <= inflight_pc;
                end else begin
                    tail_instr <= instr_in;
                    tail_pc    <= inflight_pc;
                end
            end

            if (redirect_valid)
                count <= 2'd0;
            else
                unique case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase

            if (redirect_valid)
                trap_q <= bad_target;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && count == 2'd2));
    count_bound: assert property (@(posedge clk) disable iff (!rst)
        32'(count) <= BUF_DEPTH);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a registered imem model.
// Rows describe one cycle: inputs driven and outputs expected in that cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] instr_in;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_trap;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .instr_in       (instr_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .misalign_trap  (misalign_trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0013 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) instr_in <= memf(imem_addr);

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        chk;
        logic        v;
        logic        dc;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] addr;
        logic        trap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic rdy, input logic rv,
        input logic [31:0] rpc, input logic chk, input logic v,
        input logic dc, input logic [31:0] pc, input logic [31:0] ins,
        input logic [31:0] addr, input logic trap);
        vec_t x;
        x.rst = r;   x.rdy = rdy; x.rv = rv;   x.rpc = rpc;
        x.chk = chk; x.v = v;     x.dc = dc;   x.pc = pc;
        x.ins = ins; x.addr = addr; x.trap = trap;
        return x;
    endfunction

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst            = x.rst;
        out_ready      = x.rdy;
        redirect_valid = x.rv;
        redirect_pc    = x.rpc;
        #1;
        if (x.chk) begin
            vectors++;
            if (out_valid !== x.v) begin
                miscompares++;
                $display("FAIL row%0d valid got %0b want %0b", idx, out_valid, x.v);
            end
            if (imem_addr !== x.addr) begin
                miscompares++;
                $display("FAIL row%0d addr got %h want %h", idx, imem_addr, x.addr);
            end
            if (misalign_trap !== x.trap) begin
                miscompares++;
                $display("FAIL row%0d trap got %0b want %0b", idx, misalign_trap, x.trap);
            end
            if (!x.dc) begin
                if (out_pc !== x.pc) begin
                    miscompares++;
                    $display("FAIL row%0d pc got %h want %h", idx, out_pc, x.pc);
                end
                if (out_instr !== x.ins) begin
                    miscompares++;
                    $display("FAIL row%0d instr got %h want %h", idx, out_instr, x.ins);
                end
                if (out_pc_plus4 !== x.pc + 32'd4) begin
                    miscompares++;
                    $display("FAIL row%0d pc4 got %h want %h", idx, out_pc_plus4, x.pc + 32'd4);
                end
            end
        end
    endtask

    initial begin
        // rst rdy rv rpc chk v dc pc ins addr trap
        tbl.push_back(mk(0,1,0,32'h0,  0,0,1,32'h0,  32'h0,        32'h0,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,0,32'h0,  32'h0,        32'h0,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,0,32'h0,  32'h0,        32'h4,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h0,  32'h1000_0013,32'h8,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h4,  32'h1000_0014,32'hC,  0));
        tbl.push_back(mk(1,0,0,32'h0,  1,1,0,32'h8,  32'h1000_0015,32'h10, 0));
        tbl.push_back(mk(1,0,0,32'h0,  1,1,0,32'h8,  32'h1000_0015,32'h10, 0));
        tbl.push_back(mk(1,0,0,32'h0,  1,1,0,32'h8,  32'h1000_0015,32'h10, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h8,  32'h1000_0015,32'h10, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'hC,  32'h1000_0016,32'h14, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h10, 32'h1000_0017,32'h18, 0));
        // redirect with simultaneous pop and returning read
        tbl.push_back(mk(1,1,1,32'h40, 1,1,0,32'h14, 32'h1000_0018,32'h1C, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h40, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h44, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h40, 32'h1000_0023,32'h48, 0));
        tbl.push_back(mk(1,0,0,32'h0,  1,1,0,32'h44, 32'h1000_0024,32'h4C, 0));
        // redirect with a full buffer
        tbl.push_back(mk(1,0,1,32'h100,1,1,0,32'h44, 32'h1000_0024,32'h4C, 0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h100,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h104,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h100,32'h1000_0053,32'h108,0));
        // back-to-back redirects, last wins
        tbl.push_back(mk(1,1,1,32'h200,1,1,0,32'h104,32'h1000_0054,32'h10C,0));
        tbl.push_back(mk(1,1,1,32'h300,1,0,1,32'h0,  32'h0,        32'h200,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h300,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'h304,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h300,32'h1000_00D3,32'h308,0));
        // mid-stream reset
        tbl.push_back(mk(0,1,0,32'h0,  1,1,0,32'h304,32'h1000_00D4,32'h30C,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,0,32'h0,  32'h0,        32'h0,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,0,32'h0,  32'h0,        32'h4,  0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'h0,  32'h1000_0013,32'h8,  0));
        // PC wrap at the top of the address space
        tbl.push_back(mk(1,1,1,32'hFFFF_FFF8,1,1,0,32'h4,32'h1000_0014,32'hC,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'hFFFF_FFF8,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,0,1,32'h0,  32'h0,        32'hFFFF_FFFC,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'hFFFF_FFF8,32'h5000_0011,32'h0,0));
        tbl.push_back(mk(1,1,0,32'h0,  1,1,0,32'hFFFF_FFFC,32'h5000_0012,32'h4,0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // misaligned redirect followed by an aligned one
        apply(mk(1,1,1,32'h42,1,1,0,32'h0,32'h1000_0013,32'h8,0), 100);
`ifdef FETCH_MISALIGN_TRAP_EN
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0,32'h0,32'h42,1), 101);
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0,32'h0,32'h42,1), 102);
        apply(mk(1,1,1,32'h80,1,0,1,32'h0,32'h0,32'h42,1), 103);
`else
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0,32'h0,32'h40,0), 101);
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0,32'h0,32'h44,0), 102);
        apply(mk(1,1,1,32'h80,1,1,0,32'h40,32'h1000_0023,32'h48,0), 103);
`endif
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0, 32'h0,        32'h80,0), 104);
        apply(mk(1,1,0,32'h0, 1,0,1,32'h0, 32'h0,        32'h84,0), 105);
        apply(mk(1,1,0,32'h0, 1,1,0,32'h80,32'h1000_0033,32'h88,0), 106);
        apply(mk(1,1,0,32'h0, 1,1,0,32'h84,32'h1000_0034,32'h8C,0), 107);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
